// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO block: output data and direction registers, atomic set/clear/toggle,
// synchronised input sampling with latched rising-edge events and a level interrupt.
module gpio_ctrl #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [2:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [2:0] ADDR_OUT   = 3'd0;
    localparam logic [2:0] ADDR_DIR   = 3'd1;
    localparam logic [2:0] ADDR_SET   = 3'd2;
    localparam logic [2:0] ADDR_CLR   = 3'd3;
    localparam logic [2:0] ADDR_TGL   = 3'd4;
    localparam logic [2:0] ADDR_IN    = 3'd5;
    localparam logic [2:0] ADDR_IEN   = 3'd6;
    localparam logic [2:0] ADDR_ISTAT = 3'd7;

    logic [WIDTH-1:0] out_reg, dir_reg, ien_reg, istat_reg, prev_reg;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
    logic [WIDTH-1:0] wdata_w, in_sync, rise, w1c_mask, out_next;
    logic             unused_wdata;

    // Upper write-data bits beyond WIDTH have no register behind them.
    assign wdata_w      = wdata[WIDTH-1:0];
    assign unused_wdata = ^wdata;

    assign in_sync  = sync_reg[SYNC_STAGES-1];
    assign rise     = in_sync & ~prev_reg;
    assign w1c_mask = (we && addr == ADDR_ISTAT) ? wdata_w : '0;

    always_comb begin
        out_next = out_reg;
        if (we) begin
            case (addr)
                ADDR_OUT: out_next = wdata_w;
                ADDR_SET: out_next = out_reg | wdata_w;
                ADDR_CLR: out_next = out_reg & ~wdata_w;
                ADDR_TGL: out_next = out_reg ^ wdata_w;
                default:  out_next = out_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_reg   <= '0;
            dir_reg   <= '0;
            ien_reg   <= '0;
            istat_reg <= '0;
            prev_reg  <= '0;
            sync_reg  <= '0;
        end else begin
            out_reg <= out_next;
            if (we && addr == ADDR_DIR) dir_reg <= wdata_w;
            if (we && addr == ADDR_IEN) ien_reg <= wdata_w;
            // A rising edge arriving with a clear of the same bit keeps the bit set.
            istat_reg <= (istat_reg & ~w1c_mask) | rise;
            prev_reg  <= in_sync;
            if (SYNC_STAGES > 1) sync_reg <= {sync_reg[SYNC_STAGES-2:0], gpio_in};
            else                 sync_reg <= gpio_in;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_OUT:   rdata = 32'(out_reg);
            ADDR_DIR:   rdata = 32'(dir_reg);
            ADDR_IN:    rdata = 32'(in_sync);
            ADDR_IEN:   rdata = 32'(ien_reg);
            ADDR_ISTAT: rdata = 32'(istat_reg);
            default:    rdata = '0;
        endcase
    end

    assign gpio_out = out_reg;
    assign gpio_oe  = dir_reg;
    assign irq      = |(istat_reg & ien_reg);

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: timeline model of the 8-bit instance checked every cycle,
// plus literal expectations; a 32-bit instance covers the wide toggle case.
module tb_gpio_ctrl;
    localparam int W = 8;
    localparam int S = 2;
    localparam int N = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, we;
    logic [2:0]    addr;
    logic [31:0]   wdata, rdata, rdata32;
    logic [W-1:0]  gpio_in, gpio_out, gpio_oe;
    logic [31:0]   gpio_in32, gpio_out32, gpio_oe32;
    logic          irq, irq32;

    assign gpio_in32 = 32'(gpio_in);

    gpio_ctrl #(.WIDTH(W), .SYNC_STAGES(S)) u_dut (
        .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    gpio_ctrl #(.WIDTH(32), .SYNC_STAGES(S)) u_dut32 (
        .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata32),
        .gpio_in(gpio_in32), .gpio_out(gpio_out32), .gpio_oe(gpio_oe32), .irq(irq32)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- timeline model ----------------
    logic [W-1:0] samp [N];
    bit           rst_a [N];
    int           cyc = 0;
    bit           model_valid = 0;
    logic [W-1:0] m_out, m_dir, m_ien, m_istat;
    logic [W-1:0] m_rise, m_clr, m_d;

    // Synchronised input visible after edge m: the pad value sampled S-1 edges earlier,
    // unless a reset edge fell anywhere in that window.
    function automatic logic [W-1:0] in_after(input int m);
        if (m < S - 1) return '0;
        for (int j = m - S + 1; j <= m; j++)
            if (rst_a[j]) return '0;
        return samp[m - S + 1];
    endfunction

    function automatic logic [W-1:0] prev_after(input int m);
        if (m < 0) return '0;
        if (rst_a[m]) return '0;
        return in_after(m - 1);
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_out);
            3'd1:    return 32'(m_dir);
            3'd5:    return 32'(in_after(cyc - 1));
            3'd6:    return 32'(m_ien);
            3'd7:    return 32'(m_istat);
            default: return 32'd0;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        if (cyc >= N) begin
            $display("FAIL model_capacity: got %0d cycles expected below %0d", cyc, N);
            $fatal(1);
        end
        samp[cyc]  = gpio_in;
        rst_a[cyc] = reset;
        m_rise = in_after(cyc - 1) & ~prev_after(cyc - 1);
        m_d    = wdata[W-1:0];
        m_clr  = '0;
        if (reset) begin
            m_out = '0; m_dir = '0; m_ien = '0; m_istat = '0;
            model_valid = 1'b1;
        end else begin
            if (we) begin
                case (addr)
                    3'd0: m_out = m_d;
                    3'd1: m_dir = m_d;
                    3'd2: m_out = m_out | m_d;
                    3'd3: m_out = m_out & ~m_d;
                    3'd4: m_out = m_out ^ m_d;
                    3'd6: m_ien = m_d;
                    3'd7: m_clr = m_d;
                    default: ;
                endcase
            end
            m_istat = (m_istat & ~m_clr) | m_rise;
        end
        cyc++;
    end

    // Cycle-by-cycle compare, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (model_valid) begin
            chk("gpio_out", 32'(gpio_out), 32'(m_out));
            chk("gpio_oe",  32'(gpio_oe),  32'(m_dir));
            chk("irq",      32'(irq),      32'(|(m_istat & m_ien)));
            chk("rdata",    rdata,         m_rd(addr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        $display("wr addr=%0d data=%h", a, d);
        tick();
        we = 1'b0;
    endtask

    task automatic lit(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                       input logic [31:0] exp);
        chk(name, dut_v, exp);
        chk({name, "_model"}, mdl_v, exp);
    endtask

    task automatic rd_lit(input string name, input logic [2:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        $display("rd addr=%0d data=%h", a, rdata);
        lit(name, rdata, m_rd(a), exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; we = 1'b0; addr = '0; wdata = '0; gpio_in = '0;
        tick();
        // write attempted during reset must be ignored
        we = 1'b1; addr = 3'd0; wdata = 32'hFF;
        tick();
        we = 1'b0;
        lit("rst_out", 32'(gpio_out), 32'(m_out), 32'h0);
        lit("rst_oe",  32'(gpio_oe),  32'(m_dir), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) rd_lit("rst_rd", 3'(a), 32'h0);

        // atomic operations
        wr(3'd0, 32'h0000_00F0);
        wr(3'd2, 32'h0F);
        lit("set_out", 32'(gpio_out), 32'(m_out), 32'hFF);
        wr(3'd3, 32'h30);
        lit("clr_out", 32'(gpio_out), 32'(m_out), 32'hCF);
        wr(3'd4, 32'h101);
        lit("tgl_out8", 32'(gpio_out), 32'(m_out), 32'hCE);
        chk("tgl_out32", gpio_out32, 32'h1CE);
        rd_lit("rd_set", 3'd2, 32'h0);
        rd_lit("rd_clr", 3'd3, 32'h0);
        rd_lit("rd_tgl", 3'd4, 32'h0);

        // width masking
        wr(3'd0, 32'hFFFF_FFFF);
        lit("wide_out", 32'(gpio_out), 32'(m_out), 32'hFF);
        rd_lit("wide_rd", 3'd0, 32'h0000_00FF);
        chk("wide_out32", gpio_out32, 32'hFFFF_FFFF);
        wr(3'd1, 32'hA5);
        lit("dir_oe", 32'(gpio_oe), 32'(m_dir), 32'hA5);

        // rising edge latency and interrupt
        wr(3'd6, 32'h1);
        gpio_in[0] = 1'b1;
        tick();
        rd_lit("in_k", 3'd5, 32'h0);
        tick();
        rd_lit("in_k1", 3'd5, 32'h1);
        rd_lit("istat_k1", 3'd7, 32'h0);
        tick();
        rd_lit("istat_k2", 3'd7, 32'h1);
        lit("irq_k2", 32'(irq), 32'(|(m_istat & m_ien)), 32'h1);
        gpio_in[0] = 1'b0;
        tick(); tick(); tick();
        rd_lit("istat_fall", 3'd7, 32'h1);
        wr(3'd7, 32'h1);
        lit("irq_cleared", 32'(irq), 32'(|(m_istat & m_ien)), 32'h0);
        rd_lit("istat_cleared", 3'd7, 32'h0);

        // clear colliding with a new edge on the same bit
        gpio_in[3] = 1'b1;
        tick(); tick();
        wr(3'd7, 32'h8);
        rd_lit("collide", 3'd7, 32'h8);
        gpio_in[2] = 1'b1;
        tick(); tick(); tick();
        rd_lit("ien_off", 3'd7, 32'hC);
        chk("ien_off_irq", 32'(irq), 32'h0);

        // reset mid-operation with a pin held high
        wr(3'd0, 32'h55);
        wr(3'd1, 32'hFF);
        gpio_in = '0;
        tick(); tick(); tick();
        wr(3'd7, 32'hFF);
        rd_lit("pre_clr", 3'd7, 32'h0);
        gpio_in = 8'h03;
        tick(); tick(); tick();
        rd_lit("pre_istat", 3'd7, 32'h3);
        gpio_in = 8'h01;
        reset = 1'b1;
        tick(); tick();
        lit("mid_out", 32'(gpio_out), 32'(m_out), 32'h0);
        lit("mid_oe",  32'(gpio_oe),  32'(m_dir), 32'h0);
        rd_lit("mid_istat", 3'd7, 32'h0);
        rd_lit("mid_in", 3'd5, 32'h0);
        reset = 1'b0;
        tick(); tick();
        rd_lit("rel_2", 3'd7, 32'h0);
        tick();
        rd_lit("rel_3", 3'd7, 32'h1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
